// File: rtl/vit_frame_scheduler.sv
// vit_frame_scheduler: round-robin time-sharing of one Viterbi decoder across NCH frame-buffered channels
module vit_frame_scheduler #(
   parameter int NCH        = 4,
   parameter int CH_W       = 2,
   parameter int FRAME_SYMS = 34,
   parameter int CNT_W      = 9,
   parameter int TIMEOUT    = 1023,
   parameter int TO_W       = 10,
   parameter int RST_CYC    = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NCH-1:0]  req_i,
   output logic [NCH-1:0]  gnt_o,
   output logic [CH_W-1:0] ch_sel_o,
   output logic            busy_o,
   output logic            seq_ready_o,
   input  logic            dec_oe_i,
   input  logic [1:0]      dec_dx_i,
   input  logic            dec_sync_error_i,
   output logic            dec_reset_o,
   output logic            out_valid_o,
   output logic [1:0]      out_data_o,
   output logic [CH_W-1:0] out_ch_o,
   output logic [NCH-1:0]  frame_done_o,
   output logic [NCH-1:0]  frame_err_o
);
   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      START = 5'b00010,
      RUN   = 5'b00100,
      DONE  = 5'b01000,
      ABORT = 5'b10000
   } state_t;
   state_t           state_q, state_d;
   logic [NCH-1:0]   gnt_q, gnt_d, done_q, done_d, err_q, err_d;
   logic [CH_W-1:0]  ch_q, ch_d, rr_q, rr_d, och_q, och_d, pick;
   logic             busy_q, busy_d, seq_q, seq_d, drst_q, drst_d, ov_q, ov_d;
   logic [1:0]       od_q, od_d;
   logic [CNT_W-1:0] sym_q, sym_d;
   logic [TO_W-1:0]  wd_q, wd_d;
   always_comb begin
      pick = rr_q;
      for (int i = NCH; i >= 1; i--)
         if (req_i[rr_q + CH_W'(i)]) pick = rr_q + CH_W'(i);
   end
   // wd doubles as the dec_reset hold counter while in ABORT
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ch_d    = ch_q;
      rr_d    = rr_q;
      busy_d  = busy_q;
      seq_d   = 1'b0;
      drst_d  = 1'b0;
      ov_d    = 1'b0;
      od_d    = od_q;
      och_d   = och_q;
      done_d  = '0;
      err_d   = '0;
      sym_d   = sym_q;
      wd_d    = wd_q;
      case (state_q)
         IDLE: if (|req_i) begin
            state_d = START;
            gnt_d   = NCH'(1) << pick;
            ch_d    = pick;
            busy_d  = 1'b1;
            sym_d   = '0;
            wd_d    = '0;
         end
         START: begin
            state_d = RUN;
            seq_d   = 1'b1;
         end
         RUN: begin
            if (dec_oe_i) begin
               ov_d  = 1'b1;
               od_d  = dec_dx_i;
               och_d = ch_q;
               sym_d = sym_q + 1'b1;
               wd_d  = '0;
            end else
               wd_d = wd_q + 1'b1;
            if (dec_sync_error_i || (!dec_oe_i && wd_q == TO_W'(TIMEOUT - 1))) begin
               state_d = ABORT;
               err_d   = gnt_q;
               drst_d  = 1'b1;
               wd_d    = '0;
            end else if (dec_oe_i && sym_q == CNT_W'(FRAME_SYMS - 1)) begin
               state_d = DONE;
               done_d  = gnt_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            rr_d    = ch_q;
         end
         ABORT: if (wd_q == TO_W'(RST_CYC - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            rr_d    = ch_q;
         end else begin
            drst_d = 1'b1;
            wd_d   = wd_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ch_q    <= '0;
         rr_q    <= CH_W'(NCH - 1);
         busy_q  <= 1'b0;
         seq_q   <= 1'b0;
         drst_q  <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         och_q   <= '0;
         done_q  <= '0;
         err_q   <= '0;
         sym_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ch_q    <= ch_d;
         rr_q    <= rr_d;
         busy_q  <= busy_d;
         seq_q   <= seq_d;
         drst_q  <= drst_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         och_q   <= och_d;
         done_q  <= done_d;
         err_q   <= err_d;
         sym_q   <= sym_d;
         wd_q    <= wd_d;
      end
   assign gnt_o        = gnt_q;
   assign ch_sel_o     = ch_q;
   assign busy_o       = busy_q;
   assign seq_ready_o  = seq_q;
   assign dec_reset_o  = drst_q;
   assign out_valid_o  = ov_q;
   assign out_data_o   = od_q;
   assign out_ch_o     = och_q;
   assign frame_done_o = done_q;
   assign frame_err_o  = err_q;
endmodule

// File: tb/tb_vit_frame_scheduler.sv
// tb_vit_frame_scheduler: frame-level reference model driving a decoder stand-in, directed table plus random frames
module tb_vit_frame_scheduler;
   localparam int NCH = 4, FRAME_SYMS = 34, TIMEOUT = 1023, RST_CYC = 2;
   typedef struct {
      logic [3:0] req;
      int         kind;
      int         k;
      bit         scr;
      logic [3:0] exp_gnt;
      logic [3:0] exp_done;
      logic [3:0] exp_err;
      int         exp_nout;
   } vec_t;
   logic       clock = 1'b0, reset;
   logic [3:0] req, gnt, frame_done, frame_err;
   logic [1:0] ch_sel, out_ch, dec_dx, out_data;
   logic       busy, seq_ready, dec_oe, dec_sync_error, dec_reset, out_valid;
   int         n_pass = 0, n_tot = 0;
   int         m_rr, m_owner, m_syms, m_idle, seen_out, seen_seq;
   logic [3:0] m_mask, seen_done, seen_err;
   vit_frame_scheduler dut (
      .clock(clock), .reset(reset), .req_i(req), .gnt_o(gnt), .ch_sel_o(ch_sel), .busy_o(busy),
      .seq_ready_o(seq_ready), .dec_oe_i(dec_oe), .dec_dx_i(dec_dx), .dec_sync_error_i(dec_sync_error),
      .dec_reset_o(dec_reset), .out_valid_o(out_valid), .out_data_o(out_data), .out_ch_o(out_ch),
      .frame_done_o(frame_done), .frame_err_o(frame_err)
   );
   always #5 clock = ~clock;
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish before time limit");
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
      seen_done |= frame_done;
      seen_err  |= frame_err;
      seen_out  += int'(out_valid);
      seen_seq  += int'(seq_ready);
   endtask
   function automatic int pick(input logic [3:0] r);
      logic [1:0] ix;
      for (int j = 1; j <= NCH; j++) begin
         ix = 2'((m_rr + j) % NCH);
         if (r[ix]) return int'(ix);
      end
      return -1;
   endfunction
   task automatic rand_in();
      dec_oe = 1'($urandom);
      dec_dx = 2'($urandom);
      dec_sync_error = 1'($urandom);
   endtask
   // one RUN cycle: expected outcome follows from symbol and idle counts (0 run, 1 done, 2 abort)
   task automatic step(input logic oe, input logic se, output int outc);
      logic [1:0] dx;
      dx = 2'($urandom);
      dec_oe = oe;
      dec_dx = dx;
      dec_sync_error = se;
      outc = se ? 2 : (oe && m_syms + 1 == FRAME_SYMS) ? 1 : (!oe && m_idle + 1 == TIMEOUT) ? 2 : 0;
      if (oe) begin
         m_syms++;
         m_idle = 0;
      end else m_idle++;
      tick();
      chk("out_valid", 32'(out_valid), 32'(oe));
      if (oe) begin
         chk("out_data", 32'(out_data), 32'(dx));
         chk("out_ch", 32'(out_ch), m_owner);
      end
      chk("frame_done", 32'(frame_done), outc == 1 ? 32'(m_mask) : 0);
      chk("frame_err", 32'(frame_err), outc == 2 ? 32'(m_mask) : 0);
      chk("dec_reset", 32'(dec_reset), 32'(outc == 2));
      chk("seq_ready_run", 32'(seq_ready), 0);
      chk("gnt_run", 32'(gnt), 32'(m_mask));
   endtask
   // kind: 0 full frame, 1 sync error after k-th symbol, 2 sync error with k-th symbol, 3 stall after k, 4 stop after k
   task automatic do_frame(input logic [3:0] r, input int kind, input int k, input bit scr, output logic [3:0] g);
      int outc, s, gap;
      req = r;
      seen_done = '0;
      seen_err = '0;
      seen_out = 0;
      seen_seq = 0;
      m_owner = pick(r);
      m_mask = 4'(1 << m_owner);
      m_syms = 0;
      m_idle = 0;
      rand_in();
      tick();
      g = gnt;
      chk("grant_gnt", 32'(gnt), 32'(m_mask));
      chk("grant_ch_sel", 32'(ch_sel), m_owner);
      chk("grant_busy", 32'(busy), 1);
      chk("grant_seq_ready", 32'(seq_ready), 0);
      chk("grant_out_valid", 32'(out_valid), 0);
      rand_in();
      tick();
      chk("start_seq_ready", 32'(seq_ready), 1);
      chk("start_out_valid", 32'(out_valid), 0);
      chk("start_err", 32'({frame_err, dec_reset}), 0);
      outc = 0;
      s = 0;
      while (outc == 0) begin
         if (kind == 4 && s == k) return;
         if (kind == 3 && s == k) begin
            while (outc == 0) step(1'b0, 1'b0, outc);
         end else begin
            gap = int'($urandom_range(0, 2));
            for (int i = 0; i < gap; i++) step(1'b0, 1'b0, outc);
            s++;
            step(1'b1, kind == 2 && s == k, outc);
            if (outc == 0 && kind == 1 && s == k) step(1'b0, 1'b1, outc);
            if (scr && s == 5) req = 4'($urandom);
         end
      end
      if (outc == 1) begin
         rand_in();
         tick();
         chk("done_release_gnt", 32'({gnt, busy}), 0);
         chk("done_pulse_len", 32'(frame_done), 0);
         chk("done_out_valid", 32'(out_valid), 0);
      end else begin
         for (int c = 1; c < RST_CYC; c++) begin
            rand_in();
            tick();
            chk("abort_dec_reset", 32'(dec_reset), 1);
            chk("abort_err_len", 32'(frame_err), 0);
            chk("abort_out_valid", 32'(out_valid), 0);
            chk("abort_gnt", 32'(gnt), 32'(m_mask));
         end
         rand_in();
         tick();
         chk("abort_release", 32'({gnt, busy, dec_reset}), 0);
         chk("abort_out_valid_end", 32'(out_valid), 0);
      end
      m_rr = m_owner;
      dec_oe = 1'b0;
      dec_sync_error = 1'b0;
   endtask
   initial begin
      vec_t       tbl[11];
      logic [3:0] g, r;
      int         sel, kind, k;
      tbl[0]  = '{4'b1111, 0, 0,  1'b0, 4'b0001, 4'b0001, 4'b0000, 34};
      tbl[1]  = '{4'b1111, 0, 0,  1'b0, 4'b0010, 4'b0010, 4'b0000, 34};
      tbl[2]  = '{4'b1111, 0, 0,  1'b0, 4'b0100, 4'b0100, 4'b0000, 34};
      tbl[3]  = '{4'b1111, 0, 0,  1'b0, 4'b1000, 4'b1000, 4'b0000, 34};
      tbl[4]  = '{4'b1111, 0, 0,  1'b0, 4'b0001, 4'b0001, 4'b0000, 34};
      tbl[5]  = '{4'b0010, 0, 0,  1'b0, 4'b0010, 4'b0010, 4'b0000, 34};
      tbl[6]  = '{4'b0100, 1, 10, 1'b0, 4'b0100, 4'b0000, 4'b0100, 10};
      tbl[7]  = '{4'b1001, 0, 0,  1'b0, 4'b1000, 4'b1000, 4'b0000, 34};
      tbl[8]  = '{4'b0001, 3, 5,  1'b0, 4'b0001, 4'b0000, 4'b0001, 5};
      tbl[9]  = '{4'b0010, 2, 34, 1'b0, 4'b0010, 4'b0000, 4'b0010, 34};
      tbl[10] = '{4'b0101, 0, 0,  1'b1, 4'b0100, 4'b0100, 4'b0000, 34};
      reset = 1'b1;
      req = '0;
      dec_oe = 1'b0;
      dec_dx = '0;
      dec_sync_error = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outputs", 32'({gnt, ch_sel, busy, seq_ready, dec_reset, out_valid, out_data, out_ch, frame_done, frame_err}), 0);
      reset = 1'b0;
      m_rr = NCH - 1;
      for (int i = 0; i < 11; i++) begin
         do_frame(tbl[i].req, tbl[i].kind, tbl[i].k, tbl[i].scr, g);
         chk("tbl_gnt", 32'(g), 32'(tbl[i].exp_gnt));
         chk("tbl_done", 32'(seen_done), 32'(tbl[i].exp_done));
         chk("tbl_err", 32'(seen_err), 32'(tbl[i].exp_err));
         chk("tbl_nout", seen_out, tbl[i].exp_nout);
         chk("tbl_seq_ready_count", seen_seq, 1);
      end
      do_frame(4'b0001, 4, 17, 1'b0, g);
      #2 reset = 1'b1;
      #1;
      chk("midrun_reset_outputs", 32'({gnt, ch_sel, busy, seq_ready, dec_reset, out_valid, out_data, out_ch, frame_done, frame_err}), 0);
      chk("midrun_no_done_err", 32'({seen_done, seen_err}), 0);
      @(posedge clock);
      #1 reset = 1'b0;
      m_rr = NCH - 1;
      do_frame(4'b0001, 0, 0, 1'b0, g);
      chk("post_reset_gnt", 32'(g), 32'(4'b0001));
      chk("post_reset_done", 32'(seen_done), 32'(4'b0001));
      chk("post_reset_nout", seen_out, FRAME_SYMS);
      for (int f = 0; f < 40; f++) begin
         r = 4'($urandom);
         if (r == 0) begin
            req = '0;
            for (int i = 0; i < 3; i++) begin
               rand_in();
               tick();
               chk("idle_quiet", 32'({gnt, busy, out_valid, seq_ready, frame_err}), 0);
            end
            continue;
         end
         sel = int'($urandom_range(0, 19));
         kind = sel < 14 ? 0 : sel < 17 ? 1 : sel < 19 ? 2 : 3;
         k = kind == 1 ? int'($urandom_range(1, 33)) : kind == 2 ? int'($urandom_range(1, 34)) :
             kind == 3 ? int'($urandom_range(0, 33)) : 0;
         do_frame(r, kind, k, 1'($urandom), g);
         chk("rnd_done", 32'(seen_done), kind == 0 ? 32'(m_mask) : 0);
         chk("rnd_err", 32'(seen_err), kind == 0 ? 0 : 32'(m_mask));
         chk("rnd_nout", seen_out, kind == 0 ? FRAME_SYMS : k);
         chk("rnd_seq_ready_count", seen_seq, 1);
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/vit_frame_scheduler.md
Name: vit_frame_scheduler

Overview:
- Shares one (3,2,2) Viterbi decoder control/datapath between NCH input channels, one frame at a time.
- Round-robin arbitration over channel frame requests; starts the decoder with a `seq_ready` pulse.
- Counts decoded-symbol strobes (`dec_oe`) and tags each 2-bit Dx with the owning channel.
- Aborts the frame and resets the decoder on `dec_sync_error` or watchdog timeout.

Parameters:
NCH, 4, number of requesting channels (power of 2, 2..8)
CH_W, 2, log2(NCH)
FRAME_SYMS, 34, decoded symbols per frame (N+m); frame ends on this count of dec_oe
CNT_W, 9, symbol counter width; FRAME_SYMS < 2^CNT_W
TIMEOUT, 1023, max idle cycles in RUN without a dec_oe before abort
TO_W, 10, watchdog counter width
RST_CYC, 2, cycles dec_reset is held on abort

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req  in  NCH  level; channel i has a full frame buffered; held until its frame_done/frame_err
gnt  out  NCH  one-hot owner; held for the whole frame service
ch_sel  out  CH_W  binary index of owner, drives external symbol muxes; valid while busy
busy  out  1  high from grant until release
seq_ready  out  1  one-cycle start pulse to decoder
dec_oe  in  1  decoder output enable, one cycle per decoded symbol
dec_dx  in  2  decoded symbol; undriven (z) unless dec_oe
dec_sync_error  in  1  decoder out-of-sync indication
dec_reset  out  1  synchronous reset request to decoder (ORed with system reset externally)
out_valid  out  1  registered strobe for decoded symbol
out_data  out  2  decoded symbol
out_ch  out  CH_W  channel owning out_data
frame_done  out  NCH  one-cycle pulse on owner bit at normal completion
frame_err  out  NCH  one-cycle pulse on owner bit at abort

Behaviour:
- Reset: all outputs 0; state IDLE; sym_cnt=0; wd_cnt=0; rr_last=NCH-1, so channel 0 has first priority.
- States (one-hot): IDLE, START, RUN, DONE, ABORT.
- IDLE:
  - If req!=0, pick the first set bit searching rr_last+1, rr_last+2, ... modulo NCH.
  - Register gnt, ch_sel and busy=1; clear sym_cnt and wd_cnt; go to START.
  - If req==0, stay in IDLE.
- START: seq_ready=1 for exactly this cycle; go to RUN. Latency from req seen in IDLE to seq_ready high is 2 clocks.
- RUN:
  - On dec_oe: capture dec_dx into out_data, out_ch=ch_sel, out_valid=1 next cycle (1-cycle latency); sym_cnt+1; wd_cnt cleared.
  - dec_dx is never sampled when dec_oe=0.
  - When the dec_oe that makes sym_cnt==FRAME_SYMS is accepted, go to DONE.
  - Without dec_oe, wd_cnt+1; when wd_cnt==TIMEOUT, go to ABORT.
  - dec_sync_error=1 in RUN: go to ABORT next cycle. If dec_oe is high in the same cycle, that symbol is still output.
  - Priority: sync_error > final symbol > timeout.
- DONE:
  - frame_done[owner]=1 for one cycle; gnt=0; busy=0; rr_last=owner; go to IDLE.
  - IDLE may grant again on the following cycle.
- ABORT:
  - dec_reset=1 for RST_CYC cycles; frame_err[owner]=1 on the first ABORT cycle only; dec_oe is ignored.
  - After RST_CYC cycles: gnt=0, busy=0, rr_last=owner, go to IDLE.
- req changes while granted: ignored. A dropped owner req does not cancel the frame, and new reqs wait.
- Only one of frame_done/frame_err per grant. out_valid never asserts outside RUN or the cycle after it.
- dec_sync_error/dec_oe in IDLE or START: ignored.
- sym_cnt saturates by construction (exits at FRAME_SYMS); it never wraps.
- Asynchronous reset mid-frame: immediate return to the reset values; no frame_done/frame_err is issued.

Test Plan:
- Single channel: req=4'b0010; model returns 34 dec_oe with dx=i[1:0] -> seq_ready 2 clocks after req, out_ch=1, 34 out_valid with matching data, then frame_done=4'b0010 pulse, gnt=0.
- Round robin: req=4'b1111 held for 4 frames -> grant order ch0, ch1, ch2, ch3; each gets exactly one seq_ready; then ch0 again.
- Sync error: ch2 granted; assert dec_sync_error after 10th dec_oe -> 10 symbols output, dec_reset high 2 cycles, frame_err=4'b0100 pulse, no frame_done, next grant is ch3 if requested.
- Watchdog: granted; the model stops dec_oe after 5 symbols -> ABORT exactly 1023 cycles after the last dec_oe, frame_err pulse.
- Simultaneous sync_error and dec_oe on the 34th symbol -> symbol output, ABORT (frame_err), not DONE.
- Reset asserted mid-RUN at symbol 17 -> all outputs 0 same cycle; after release with req=4'b0001, a fresh frame counts from 0 and completes with 34 symbols.
